// File: rtl/shr_serializer.sv
// shr_serializer: snapshots a parallel pattern on a synchronized udr edge and shifts it MSB-first to an on-chip shift register
// Ports: clk/aclr_n board clock and async active-low reset; pattern/udr parallel word and JTAG update strobe;
// shr_clk/shr_data/shr_load serial interface to the DUT; busy/done/overrun transfer status.
module shr_serializer #(
  parameter int WIDTH   = 626,
  parameter int CLK_DIV = 25
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic [WIDTH-1:0] pattern,
  input  logic             udr,
  output logic             shr_clk,
  output logic             shr_data,
  output logic             shr_load,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, LATCH, DONE} state_t;
  state_t           state, state_nxt;
  logic [DW-1:0]    div, div_nxt;
  logic [BW-1:0]    bitn, bitn_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic             s1, s2, s3, req, ovr_nxt, div_end;
  assign req     = s2 & ~s3;
  assign div_end = div == DW'(CLK_DIV - 1);
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_end ? '0 : div + DW'(1);
    bitn_nxt   = bitn;
    shadow_nxt = shadow;
    ovr_nxt    = overrun | (req & (state != IDLE));
    case (state)
      IDLE: begin
        div_nxt = '0;
        if (req) begin
          state_nxt  = LOW;
          shadow_nxt = pattern;
          bitn_nxt   = BW'(WIDTH - 1);
          ovr_nxt    = 1'b0;
        end
      end
      LOW:   state_nxt = div_end ? HIGH : LOW;
      HIGH:
        if (div_end) begin
          if (bitn == '0) state_nxt = LATCH;
          else begin
            state_nxt  = LOW;
            shadow_nxt = shadow << 1;
            bitn_nxt   = bitn - BW'(1);
          end
        end
      LATCH: state_nxt = div_end ? DONE : LATCH;
      default: state_nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next-state values so they align with the state register and never glitch.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      {s1, s2, s3} <= '1;
      state        <= IDLE;
      div          <= '0;
      bitn         <= '0;
      shadow       <= '0;
      overrun      <= 1'b0;
      shr_clk      <= 1'b0;
      shr_data     <= 1'b0;
      shr_load     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      s1       <= udr;
      s2       <= s1;
      s3       <= s2;
      state    <= state_nxt;
      div      <= div_nxt;
      bitn     <= bitn_nxt;
      shadow   <= shadow_nxt;
      overrun  <= ovr_nxt;
      shr_clk  <= state_nxt == HIGH;
      shr_data <= (state_nxt == LOW || state_nxt == HIGH) & shadow_nxt[WIDTH-1];
      shr_load <= state_nxt == LATCH;
      busy     <= state_nxt != IDLE;
      done     <= state_nxt == DONE;
    end
  end
endmodule

// File: tb/tb_shr_serializer.sv
// tb_shr_serializer: directed self-checking bench for shr_serializer at 8/2 and 626/1 geometries
module tb_shr_serializer;
  logic         clk = 1'b0;
  logic         aclr_n = 1'b0;
  logic [7:0]   pattern8 = 8'h00;
  logic         udr8 = 1'b0;
  logic         shr_clk8, shr_data8, shr_load8, busy8, done8, overrun8;
  logic [625:0] pattern626 = '0;
  logic         udr626 = 1'b0;
  logic         shr_clk626, shr_data626, shr_load626, busy626, done626, overrun626;
  int           total = 0, bad = 0;
  logic         prev8 = 1'b0, prev626 = 1'b0;
  logic [7:0]   word8 = '0;
  logic [625:0] word626 = '0;
  int           pulses8 = 0, hirun8 = 0, lowrun8 = 0, badhi8 = 0, badlow8 = 0;
  int           busy8_n = 0, load8_n = 0, done8_n = 0, busy626_n = 0;
  always #5 clk = ~clk;
  shr_serializer #(.WIDTH(8), .CLK_DIV(2)) dut8 (
    .clk(clk), .aclr_n(aclr_n), .pattern(pattern8), .udr(udr8),
    .shr_clk(shr_clk8), .shr_data(shr_data8), .shr_load(shr_load8),
    .busy(busy8), .done(done8), .overrun(overrun8));
  shr_serializer #(.WIDTH(626), .CLK_DIV(1)) dut626 (
    .clk(clk), .aclr_n(aclr_n), .pattern(pattern626), .udr(udr626),
    .shr_clk(shr_clk626), .shr_data(shr_data626), .shr_load(shr_load626),
    .busy(busy626), .done(done626), .overrun(overrun626));
  always @(negedge clk) begin
    prev8   <= shr_clk8;
    prev626 <= shr_clk626;
    if (shr_clk8 && !prev8) begin
      word8   <= {word8[6:0], shr_data8};
      pulses8 <= pulses8 + 1;
      if (lowrun8 != 2) badlow8 <= badlow8 + 1;
    end
    if (!busy8 || (shr_clk8 && !prev8)) lowrun8 <= 0;
    else if (!shr_clk8) lowrun8 <= lowrun8 + 1;
    if (shr_clk8) hirun8 <= hirun8 + 1;
    else if (prev8) begin
      if (hirun8 != 2) badhi8 <= badhi8 + 1;
      hirun8 <= 0;
    end
    if (shr_clk626 && !prev626) word626 <= {word626[624:0], shr_data626};
    if (busy8) busy8_n <= busy8_n + 1;
    if (shr_load8) load8_n <= load8_n + 1;
    if (done8) done8_n <= done8_n + 1;
    if (busy626) busy626_n <= busy626_n + 1;
  end
  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_w(input string tag, input logic [625:0] obs, input logic [625:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(input bit wide, input int lim);
    int n = 0;
    while (!(wide ? done626 : done8) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk_i(wide ? "done626_seen" : "done8_seen", int'(n < lim), 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic pulse8;
    @(negedge clk) udr8 = 1'b1;
    repeat (3) @(negedge clk);
    udr8 = 1'b0;
  endtask
  int p0, b0, l0, d0, hi0, lo0, n;
  logic [639:0] rnd;
  initial begin
    repeat (3) @(negedge clk);
    chk_i("reset_outs8", int'({shr_clk8, shr_data8, shr_load8, busy8, done8, overrun8}), 0);
    chk_i("reset_outs626", int'({shr_clk626, shr_data626, shr_load626, busy626, done626, overrun626}), 0);
    aclr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_i("idle_after_release", int'(busy8), 0);
    // basic shift with start latency
    pattern8 = 8'hA5;
    p0 = pulses8; b0 = busy8_n; l0 = load8_n; d0 = done8_n; hi0 = badhi8; lo0 = badlow8;
    udr8 = 1'b1;
    @(negedge clk);
    chk_i("latency_e0_busy", int'(busy8), 0);
    @(negedge clk);
    chk_i("latency_e1_busy", int'(busy8), 0);
    @(negedge clk);
    chk_i("latency_e2_busy", int'(busy8), 1);
    chk_i("first_data_msb", int'(shr_data8), 1);
    @(negedge clk) udr8 = 1'b0;
    wait_done(1'b0, 100);
    chk_i("basic_word", int'(word8), 'hA5);
    chk_i("basic_pulses", pulses8 - p0, 8);
    chk_i("basic_high_width", badhi8 - hi0, 0);
    chk_i("basic_low_width", badlow8 - lo0, 0);
    chk_i("basic_load_cycles", load8_n - l0, 2);
    chk_i("basic_done_pulses", done8_n - d0, 1);
    chk_i("basic_busy_cycles", busy8_n - b0, 35);
    chk_i("basic_overrun", int'(overrun8), 0);
    chk_i("idle_data_zero", int'(shr_data8), 0);
    // overrun: second edge mid-transfer
    pattern8 = 8'h3C;
    b0 = busy8_n; p0 = pulses8;
    pulse8();
    repeat (10) @(negedge clk);
    pulse8();
    repeat (2) @(negedge clk);
    chk_i("overrun_set", int'(overrun8), 1);
    wait_done(1'b0, 100);
    chk_i("overrun_word", int'(word8), 'h3C);
    chk_i("overrun_pulses", pulses8 - p0, 8);
    chk_i("overrun_busy_cycles", busy8_n - b0, 35);
    chk_i("overrun_sticky", int'(overrun8), 1);
    pattern8 = 8'h5A;
    pulse8();
    chk_i("overrun_cleared", int'({busy8, overrun8}), 'b10);
    wait_done(1'b0, 100);
    chk_i("after_overrun_word", int'(word8), 'h5A);
    // pattern isolation
    pattern8 = 8'hFF;
    pulse8();
    repeat (6) @(negedge clk);
    pattern8 = 8'h00;
    wait_done(1'b0, 100);
    chk_i("isolation_word", int'(word8), 'hFF);
    // reset mid-transfer at bit 3
    pattern8 = 8'hC3;
    p0 = pulses8; l0 = load8_n;
    pulse8();
    n = 0;
    while (pulses8 - p0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_i("reached_bit3", int'(n < 100), 1);
    #2 aclr_n = 1'b0;
    #1 chk_i("async_reset_outs", int'({shr_clk8, shr_data8, shr_load8, busy8, done8, overrun8}), 0);
    repeat (4) @(negedge clk);
    chk_i("abort_no_load", load8_n - l0, 0);
    aclr_n = 1'b1;
    repeat (2) @(negedge clk);
    pattern8 = 8'h96;
    p0 = pulses8; l0 = load8_n;
    pulse8();
    wait_done(1'b0, 100);
    chk_i("post_reset_word", int'(word8), 'h96);
    chk_i("post_reset_pulses", pulses8 - p0, 8);
    chk_i("post_reset_load", load8_n - l0, 2);
    // reset released with udr held high
    aclr_n = 1'b0;
    udr8 = 1'b1;
    repeat (3) @(negedge clk);
    aclr_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy8) n = 1;
    end
    chk_i("udr_high_no_start", n, 0);
    pattern8 = 8'h81;
    udr8 = 1'b0;
    repeat (2) @(negedge clk);
    udr8 = 1'b1;
    wait_done(1'b0, 100);
    chk_i("udr_rearm_word", int'(word8), 'h81);
    udr8 = 1'b0;
    // default size
    for (int i = 0; i < 20; i++) rnd[i*32 +: 32] = $urandom;
    pattern626 = rnd[625:0];
    b0 = busy626_n;
    @(negedge clk) udr626 = 1'b1;
    repeat (3) @(negedge clk);
    udr626 = 1'b0;
    wait_done(1'b1, 3000);
    chk_w("wide_word", word626, pattern626);
    chk_i("wide_busy_cycles", busy626_n - b0, 1254);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
